issueque_int: RTL and testbench

ISSUEQUE_INT -- requirements
Module: issueque_int

---
 rtl/issueque_int.sv | 163 ++++++++++++++++
 tb/tb_issueque_int.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/issueque_int.sv
// Four-entry age-ordered integer issue queue with CDB wakeup, same-cycle CDB bypass
// on dispatch, oldest-ready selection and compaction of younger entries on issue.
module issueque_int #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dispatch_en,
    input  logic [3:0]        dispatch_opcode,
    input  logic [DATA_W-1:0] dispatch_rsdata,
    input  logic [DATA_W-1:0] dispatch_rtdata,
    input  logic              dispatch_rsvalid,
    input  logic              dispatch_rtvalid,
    input  logic [5:0]        dispatch_rstag,
    input  logic [5:0]        dispatch_rttag,
    input  logic [5:0]        dispatch_rdtag,
    input  logic              flush,
    input  logic              cdb_valid,
    input  logic [5:0]        cdb_tagout,
    input  logic [DATA_W-1:0] cdb_out,
    input  logic              issue_int,
    output logic              ready_int,
    output logic [3:0]        issueque_opcode,
    output logic [DATA_W-1:0] issueque_rsdata,
    output logic [DATA_W-1:0] issueque_rtdata,
    output logic [5:0]        issueque_rdtag,
    output logic              dispatch_full
);

    localparam int DEPTH = 4;

    logic [DEPTH-1:0]  valid_p0, rsvalid_p0, rtvalid_p0;
    logic [3:0]        opcode_p0 [DEPTH];
    logic [DATA_W-1:0] rsdata_p0 [DEPTH];
    logic [DATA_W-1:0] rtdata_p0 [DEPTH];
    logic [5:0]        rstag_p0  [DEPTH];
    logic [5:0]        rttag_p0  [DEPTH];
    logic [5:0]        rdtag_p0  [DEPTH];
    logic [2:0]        count_p0;

    logic [DEPTH-1:0]  valid_nxt, rsvalid_nxt, rtvalid_nxt;
    logic [3:0]        opcode_nxt [DEPTH];
    logic [DATA_W-1:0] rsdata_nxt [DEPTH];
    logic [DATA_W-1:0] rtdata_nxt [DEPTH];
    logic [5:0]        rstag_nxt  [DEPTH];
    logic [5:0]        rttag_nxt  [DEPTH];
    logic [5:0]        rdtag_nxt  [DEPTH];
    logic [2:0]        count_nxt;

    logic [DEPTH-1:0]  ready_vec;
    logic [1:0]        sel;
    logic [2:0]        src [DEPTH];
    logic [2:0]        wr_idx;
    logic              issue_fire, accept;
    logic              byp_rs, byp_rt;

    function automatic logic tag_hit(input logic src_valid, input logic [5:0] src_tag,
                                     input logic bus_valid, input logic [5:0] bus_tag);
        return bus_valid && !src_valid && (src_tag == bus_tag);
    endfunction

    // Selection: oldest entry whose operands are both present
    always_comb begin
        ready_vec = valid_p0 & rsvalid_p0 & rtvalid_p0;
        sel = 2'd0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) sel = 2'(i);
        end
    end

    assign ready_int     = |ready_vec;
    assign dispatch_full = (count_p0 == 3'(DEPTH));
    assign issue_fire    = issue_int && ready_int;
    assign accept        = dispatch_en && !dispatch_full;
    assign wr_idx        = count_p0 - {2'b00, issue_fire};
    assign byp_rs        = tag_hit(dispatch_rsvalid, dispatch_rstag, cdb_valid, cdb_tagout);
    assign byp_rt        = tag_hit(dispatch_rtvalid, dispatch_rttag, cdb_valid, cdb_tagout);

    always_comb begin
        issueque_opcode = '0;
        issueque_rsdata = '0;
        issueque_rtdata = '0;
        issueque_rdtag  = '0;
        if (ready_int) begin
            issueque_opcode = opcode_p0[sel];
            issueque_rsdata = rsdata_p0[sel];
            issueque_rtdata = rtdata_p0[sel];
            issueque_rdtag  = rdtag_p0[sel];
        end
    end

    // Each slot at or above the issued one pulls from its younger neighbour
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            src[j] = (issue_fire && (3'(j) >= {1'b0, sel})) ? 3'(j + 1) : 3'(j);
        end
    end

    always_comb begin
        count_nxt   = count_p0 - {2'b00, issue_fire} + {2'b00, accept};
        valid_nxt   = '0;
        rsvalid_nxt = '0;
        rtvalid_nxt = '0;
        for (int j = 0; j < DEPTH; j++) begin
            opcode_nxt[j] = '0;
            rsdata_nxt[j] = '0;
            rtdata_nxt[j] = '0;
            rstag_nxt[j]  = '0;
            rttag_nxt[j]  = '0;
            rdtag_nxt[j]  = '0;
            if (src[j] < 3'(DEPTH)) begin
                valid_nxt[j]   = valid_p0[src[j][1:0]];
                rsvalid_nxt[j] = rsvalid_p0[src[j][1:0]];
                rtvalid_nxt[j] = rtvalid_p0[src[j][1:0]];
                opcode_nxt[j]  = opcode_p0[src[j][1:0]];
                rsdata_nxt[j]  = rsdata_p0[src[j][1:0]];
                rtdata_nxt[j]  = rtdata_p0[src[j][1:0]];
                rstag_nxt[j]   = rstag_p0[src[j][1:0]];
                rttag_nxt[j]   = rttag_p0[src[j][1:0]];
                rdtag_nxt[j]   = rdtag_p0[src[j][1:0]];
                if (valid_nxt[j] && tag_hit(rsvalid_nxt[j], rstag_nxt[j], cdb_valid, cdb_tagout)) begin
                    rsvalid_nxt[j] = 1'b1;
                    rsdata_nxt[j]  = cdb_out;
                end
                if (valid_nxt[j] && tag_hit(rtvalid_nxt[j], rttag_nxt[j], cdb_valid, cdb_tagout)) begin
                    rtvalid_nxt[j] = 1'b1;
                    rtdata_nxt[j]  = cdb_out;
                end
            end
        end
        if (accept) begin
            valid_nxt[wr_idx[1:0]]   = 1'b1;
            opcode_nxt[wr_idx[1:0]]  = dispatch_opcode;
            rsvalid_nxt[wr_idx[1:0]] = dispatch_rsvalid || byp_rs;
            rtvalid_nxt[wr_idx[1:0]] = dispatch_rtvalid || byp_rt;
            rsdata_nxt[wr_idx[1:0]]  = byp_rs ? cdb_out : dispatch_rsdata;
            rtdata_nxt[wr_idx[1:0]]  = byp_rt ? cdb_out : dispatch_rtdata;
            rstag_nxt[wr_idx[1:0]]   = dispatch_rstag;
            rttag_nxt[wr_idx[1:0]]   = dispatch_rttag;
            rdtag_nxt[wr_idx[1:0]]   = dispatch_rdtag;
        end
    end

    // State register: reset and flush clear only the occupancy, payload follows next-state
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_p0 <= '0;
            count_p0 <= '0;
        end else begin
            valid_p0 <= valid_nxt;
            count_p0 <= count_nxt;
        end
        rsvalid_p0 <= rsvalid_nxt;
        rtvalid_p0 <= rtvalid_nxt;
        opcode_p0  <= opcode_nxt;
        rsdata_p0  <= rsdata_nxt;
        rtdata_p0  <= rtdata_nxt;
        rstag_p0   <= rstag_nxt;
        rttag_p0   <= rttag_nxt;
        rdtag_p0   <= rdtag_nxt;
    end

endmodule

// File: tb/tb_issueque_int.sv
// Directed vector bench for issueque_int: table of per-cycle stimulus with expected
// post-edge outputs, followed by a hand-built rt-wakeup sequence.
module tb_issueque_int;

    typedef struct packed {
        logic        rst;
        logic        fl;
        logic        de;
        logic [3:0]  op;
        logic [31:0] rs;
        logic        rsv;
        logic [5:0]  rstag;
        logic [31:0] rt;
        logic        rtv;
        logic [5:0]  rttag;
        logic [5:0]  rd;
        logic        cv;
        logic [5:0]  ct;
        logic [31:0] cd;
        logic        iss;
        logic        e_rdy;
        logic        e_full;
        logic [3:0]  e_op;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [5:0]  e_rd;
    } vec_t;

    localparam int NV = 31;

    logic        clk = 1'b0;
    logic        reset, dispatch_en, dispatch_rsvalid, dispatch_rtvalid, flush, cdb_valid, issue_int;
    logic [3:0]  dispatch_opcode;
    logic [31:0] dispatch_rsdata, dispatch_rtdata, cdb_out;
    logic [5:0]  dispatch_rstag, dispatch_rttag, dispatch_rdtag, cdb_tagout;
    logic        ready_int, dispatch_full;
    logic [3:0]  issueque_opcode;
    logic [31:0] issueque_rsdata, issueque_rtdata;
    logic [5:0]  issueque_rdtag;

    int passed = 0;
    int total  = 0;
    vec_t tbl [NV];
    vec_t v;

    issueque_int dut (
        .clk(clk), .reset(reset), .dispatch_en(dispatch_en), .dispatch_opcode(dispatch_opcode),
        .dispatch_rsdata(dispatch_rsdata), .dispatch_rtdata(dispatch_rtdata),
        .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtvalid(dispatch_rtvalid),
        .dispatch_rstag(dispatch_rstag), .dispatch_rttag(dispatch_rttag),
        .dispatch_rdtag(dispatch_rdtag), .flush(flush), .cdb_valid(cdb_valid),
        .cdb_tagout(cdb_tagout), .cdb_out(cdb_out), .issue_int(issue_int),
        .ready_int(ready_int), .issueque_opcode(issueque_opcode),
        .issueque_rsdata(issueque_rsdata), .issueque_rtdata(issueque_rtdata),
        .issueque_rdtag(issueque_rdtag), .dispatch_full(dispatch_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic apply(input vec_t x, input string tag);
        reset            = x.rst;
        flush            = x.fl;
        dispatch_en      = x.de;
        dispatch_opcode  = x.op;
        dispatch_rsdata  = x.rs;
        dispatch_rsvalid = x.rsv;
        dispatch_rstag   = x.rstag;
        dispatch_rtdata  = x.rt;
        dispatch_rtvalid = x.rtv;
        dispatch_rttag   = x.rttag;
        dispatch_rdtag   = x.rd;
        cdb_valid        = x.cv;
        cdb_tagout       = x.ct;
        cdb_out          = x.cd;
        issue_int        = x.iss;
        @(posedge clk);
        #1;
        chk({tag, ".ready_int"},     32'(ready_int),       32'(x.e_rdy));
        chk({tag, ".dispatch_full"}, 32'(dispatch_full),   32'(x.e_full));
        chk({tag, ".opcode"},        32'(issueque_opcode), 32'(x.e_op));
        chk({tag, ".rsdata"},        issueque_rsdata,      x.e_rs);
        chk({tag, ".rtdata"},        issueque_rtdata,      x.e_rt);
        chk({tag, ".rdtag"},         32'(issueque_rdtag),  32'(x.e_rd));
    endtask

    initial begin
        //          rst fl  de op  rs     rsv rstag rt    rtv rttag rd   cv ct  cd     iss  rdy full op  rs     rt     rd
        tbl[0]  = '{1, 0,  0, 0,  0,     0,  0,  0,     0,  0,  0,   0, 0,  0,     0,   0, 0,  0,  0,     0,     0};
        tbl[1]  = '{0, 0,  1, 1,  5,     1,  0,  3,     1,  0,  9,   0, 0,  0,     0,   1, 0,  1,  5,     3,     9};
        tbl[2]  = '{0, 0,  0, 0,  0,     0,  0,  0,     0,  0,  0,   0, 0,  0,     1,   0, 0,  0,  0,     0,     0};
        tbl[3]  = '{0, 0,  1, 2,  0,     0,  12, 7,     1,  0,  10,  0, 0,  0,     0,   0, 0,  0,  0,     0,     0};
        tbl[4]  = '{0, 0,  0, 0,  0,     0,  0,  0,     0,  0,  0,   1, 12, 'hAA,  0,   1, 0,  2,  'hAA,  7,     10};
        tbl[5]  = '{0, 0,  0, 0,  0,     0,  0,  0,     0,  0,  0,   0, 0,  0,     1,   0, 0,  0,  0,     0,     0};
        tbl[6]  = '{0, 0,  1, 3,  0,     0,  7,  1,     1,  0,  11,  1, 7,  'h11,  0,   1, 0,  3,  'h11,  1,     11};
        tbl[7]  = '{0, 0,  0, 0,  0,     0,  0,  0,     0,  0,  0,   0, 0,  0,     1,   0, 0,  0,  0,     0,     0};
        tbl[8]  = '{0, 0,  1, 4,  0,     0,  20, 0,     1,  0,  1,   0, 0,  0,     0,   0, 0,  0,  0,     0,     0};
        tbl[9]  = '{0, 0,  1, 5,  0,     0,  21, 0,     1,  0,  2,   0, 0,  0,     0,   0, 0,  0,  0,     0,     0};
        tbl[10] = '{0, 0,  1, 6,  0,     0,  22, 0,     1,  0,  3,   0, 0,  0,     0,   0, 0,  0,  0,     0,     0};
        tbl[11] = '{0, 0,  1, 7,  0,     0,  23, 0,     1,  0,  4,   0, 0,  0,     0,   0, 1,  0,  0,     0,     0};
        tbl[12] = '{0, 0,  1, 8,  5,     1,  0,  6,     1,  0,  5,   0, 0,  0,     0,   0, 1,  0,  0,     0,     0};
        tbl[13] = '{0, 0,  0, 0,  0,     0,  0,  0,     0,  0,  0,   1, 21, 'h21,  0,   1, 1,  5,  'h21,  0,     2};
        tbl[14] = '{0, 0,  0, 0,  0,     0,  0,  0,     0,  0,  0,   1, 20, 'h20,  1,   1, 0,  4,  'h20,  0,     1};
        tbl[15] = '{0, 0,  1, 9,  'h99,  1,  0,  'h98,  1,  0,  6,   1, 23, 'h23,  1,   1, 0,  7,  'h23,  0,     4};
        tbl[16] = '{0, 0,  0, 0,  0,     0,  0,  0,     0,  0,  0,   0, 0,  0,     1,   1, 0,  9,  'h99,  'h98,  6};
        tbl[17] = '{0, 0,  1, 10, 1,     1,  0,  2,     1,  0,  7,   0, 0,  0,     0,   1, 0,  9,  'h99,  'h98,  6};
        tbl[18] = '{0, 0,  1, 1,  'h31,  1,  0,  'h32,  1,  0,  16,  0, 0,  0,     1,   1, 0,  10, 1,     2,     7};
        tbl[19] = '{0, 0,  1, 3,  'h41,  1,  0,  'h42,  1,  0,  20,  0, 0,  0,     0,   1, 1,  10, 1,     2,     7};
        tbl[20] = '{0, 1,  1, 15, 1,     1,  0,  1,     1,  0,  15,  0, 0,  0,     0,   0, 0,  0,  0,     0,     0};
        tbl[21] = '{0, 0,  1, 11, 'hB1,  1,  0,  'hB2,  1,  0,  8,   0, 0,  0,     0,   1, 0,  11, 'hB1,  'hB2,  8};
        tbl[22] = '{0, 0,  1, 12, 'hC1,  1,  0,  'hC2,  1,  0,  12,  0, 0,  0,     0,   1, 0,  11, 'hB1,  'hB2,  8};
        tbl[23] = '{0, 0,  1, 13, 'hD1,  1,  0,  'hD2,  1,  0,  13,  0, 0,  0,     0,   1, 0,  11, 'hB1,  'hB2,  8};
        tbl[24] = '{1, 0,  1, 14, 'hE1,  1,  0,  'hE2,  1,  0,  14,  1, 5,  'h55,  1,   0, 0,  0,  0,     0,     0};
        tbl[25] = '{0, 0,  0, 0,  0,     0,  0,  0,     0,  0,  0,   0, 0,  0,     1,   0, 0,  0,  0,     0,     0};
        tbl[26] = '{0, 0,  1, 14, 'hE1,  1,  0,  'hE2,  1,  0,  14,  0, 0,  0,     0,   1, 0,  14, 'hE1,  'hE2,  14};
        tbl[27] = '{0, 0,  1, 2,  'h21,  1,  0,  'h22,  1,  0,  17,  0, 0,  0,     0,   1, 0,  14, 'hE1,  'hE2,  14};
        tbl[28] = '{0, 0,  1, 2,  'h21,  1,  0,  'h22,  1,  0,  18,  0, 0,  0,     0,   1, 0,  14, 'hE1,  'hE2,  14};
        tbl[29] = '{0, 0,  1, 2,  'h21,  1,  0,  'h22,  1,  0,  19,  0, 0,  0,     0,   1, 1,  14, 'hE1,  'hE2,  14};
        tbl[30] = '{0, 1,  0, 0,  0,     0,  0,  0,     0,  0,  0,   0, 0,  0,     0,   0, 0,  0,  0,     0,     0};

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // rt waits on tag 33; rs already valid with the same tag must not be overwritten
        v = '0;
        v.de = 1'b1; v.op = 4'd6; v.rs = 32'h40; v.rsv = 1'b1; v.rstag = 6'd33;
        v.rtv = 1'b0; v.rttag = 6'd33; v.rd = 6'd21;
        apply(v, "rt_dispatch");
        v = '0;
        for (int k = 0; k < 3; k++) apply(v, $sformatf("rt_idle%0d", k));
        v.cv = 1'b1; v.ct = 6'd34; v.cd = 32'h99;
        apply(v, "rt_wrong_tag");
        v = '0;
        v.cv = 1'b1; v.ct = 6'd33; v.cd = 32'h77;
        v.e_rdy = 1'b1; v.e_op = 4'd6; v.e_rs = 32'h40; v.e_rt = 32'h77; v.e_rd = 6'd21;
        apply(v, "rt_wake");
        v = '0;
        v.iss = 1'b1;
        apply(v, "rt_issue");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
